// File: rtl/shift_unit_pkg.sv
// Shared definitions for the pipelined shift unit.
//   OP_*          operation codes presented on in_op
//   lvl_range_t   first mux level and level count handled by one stage
//   stage_levels  splits the shift-amount mux levels across the register stages
package shift_unit_pkg;

    localparam logic [2:0] OP_SLA = 3'b000;
    localparam logic [2:0] OP_SRA = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    typedef struct packed {
        logic [7:0] lo;
        logic [7:0] cnt;
    } lvl_range_t;

    // Every stage gets shw/stages levels. The first (shw % stages) stages
    // each take one more level, so the levels stay contiguous and in order.
    function automatic lvl_range_t stage_levels(input int k, input int shw, input int stages);
        int base;
        int extra;
        lvl_range_t r;
        base  = shw / stages;
        extra = shw % stages;
        r.lo  = 8'(k * base + ((k < extra) ? k : extra));
        r.cnt = 8'(base + ((k < extra) ? 1 : 0));
        return r;
    endfunction

    function automatic logic op_is_illegal(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One register stage of the shift pipeline. It applies mux levels LO..LO+CNT-1
// (level i shifts by 2^i when shamt bit i is set), accumulates SLA overflow
// and registers the result when the downstream side lets it advance.
//   clk, reset         clock, async active-high reset
//   adv_i              this stage may load this cycle
//   valid_i .. ovf_i   operation arriving from the previous stage (or the input port)
//   valid_o .. ovf_o   registered operation held by this stage
module shift_stage
    import shift_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int LO    = 0,
    parameter int CNT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic [2:0]       op_i,
    input  logic             ovf_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [SHW-1:0]   shamt_o,
    output logic [2:0]       op_o,
    output logic             ovf_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [SHW-1:0]   shamt_q;
    logic [2:0]       op_q;
    logic             ovf_q;
    logic             ovf_d;

    logic [WIDTH-1:0] top_mask;
    logic [SHW-1:0]   amt;
    int               step;

    always_comb begin
        data_d   = data_i;
        ovf_d    = ovf_i;
        top_mask = '0;
        step     = 0;
        amt      = shamt_i >> LO;
        for (int j = 0; j < CNT; j++) begin
            step = 1 << (LO + j);
            // Bits that leave the word plus the new sign bit must all match the
            // current sign; checking each partial shift this way is equivalent
            // to checking the whole a[WIDTH-1 : WIDTH-1-shamt] span at once.
            top_mask = ~({WIDTH{1'b1}} >> (step + 1));
            if (amt[0]) begin
                if (op_i == OP_SLA && (data_d & top_mask) != '0 && (data_d & top_mask) != top_mask) begin
                    ovf_d = 1'b1;
                end
                case (op_i)
                    OP_SLA, OP_SLL: data_d = data_d << step;
                    OP_SRA:         data_d = $signed(data_d) >>> step;
                    OP_SRL:         data_d = data_d >> step;
                    OP_ROL:         data_d = (data_d << step) | (data_d >> (WIDTH - step));
                    OP_ROR:         data_d = (data_d >> step) | (data_d << (WIDTH - step));
                    default:        data_d = '0;
                endcase
            end
            amt = amt >> 1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= '0;
            ovf_q   <= 1'b0;
        end else if (adv_i) begin
            valid_q <= valid_i;
            // Payload only moves with a real operation so bubbles never disturb it.
            if (valid_i) begin
                data_q  <= data_d;
                shamt_q <= shamt_i;
                op_q    <= op_i;
                ovf_q   <= ovf_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign op_o    = op_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/pipelined_shift_unit.sv
// Pipelined shift/rotate unit with valid/ready on both sides.
//   clk, reset                 clock, async active-high reset
//   in_valid/in_ready          operation handshake from issue
//   in_a, in_shamt, in_op      operand, shift amount, operation code
//   out_valid/out_ready        result handshake to writeback
//   out_c                      result
//   out_zero, out_neg          result flags
//   out_overflow, out_illegal  SLA significance loss, undefined opcode
module pipelined_shift_unit
    import shift_unit_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [2:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_c,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic                     out_overflow,
    output logic                     out_illegal
);

    localparam int SHW = $clog2(WIDTH);

    // Index 0 is the input port; index k+1 is the register of stage k.
    logic [STAGES:0]            valid_s;
    logic [STAGES:0][WIDTH-1:0] data_s;
    logic [STAGES:0][SHW-1:0]   shamt_s;
    logic [STAGES:0][2:0]       op_s;
    logic [STAGES:0]            ovf_s;
    logic [STAGES-1:0]          adv;

    assign valid_s[0] = in_valid;
    assign data_s[0]  = op_is_illegal(in_op) ? '0 : in_a;
    assign shamt_s[0] = in_shamt;
    assign op_s[0]    = in_op;
    assign ovf_s[0]   = 1'b0;

    // Stage k may load when it or any stage after it is empty, or when the
    // consumer takes the result. Written out flat so the ready chain is a
    // function of register state and out_ready only.
    always_comb begin
        adv = '0;
        for (int k = 0; k < STAGES; k++) begin
            adv[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!valid_s[j+1]) begin
                    adv[k] = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam lvl_range_t R = stage_levels(k, SHW, STAGES);
        shift_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .LO    (int'(R.lo)),
            .CNT   (int'(R.cnt))
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .adv_i   (adv[k]),
            .valid_i (valid_s[k]),
            .data_i  (data_s[k]),
            .shamt_i (shamt_s[k]),
            .op_i    (op_s[k]),
            .ovf_i   (ovf_s[k]),
            .valid_o (valid_s[k+1]),
            .data_o  (data_s[k+1]),
            .shamt_o (shamt_s[k+1]),
            .op_o    (op_s[k+1]),
            .ovf_o   (ovf_s[k+1])
        );
    end

    logic unused_shamt;
    assign unused_shamt = ^shamt_s[STAGES];

    assign in_ready  = adv[0];
    assign out_valid = valid_s[STAGES];
    assign out_c     = data_s[STAGES];

    // Flags are qualified with out_valid so they read 0 out of reset.
    assign out_zero     = out_valid && (data_s[STAGES] == '0);
    assign out_neg      = out_valid && data_s[STAGES][WIDTH-1];
    assign out_overflow = out_valid && ovf_s[STAGES] && (op_s[STAGES] == OP_SLA);
    assign out_illegal  = out_valid && op_is_illegal(op_s[STAGES]);

endmodule
